cmp32_bist: RTL and testbench
=============================

# cmp32_bist

Self-checking built-in self-test engine for the 32-bit equality comparator `cmp32`. It drives operand pairs into a `cmp32` instance, computes the golden result itself, checks the comparator's `y` output every cycle and accumulates pass/fail counts. Each run applies NUM_RANDOM LFSR-generated vectors followed by four directed corner vectors. It sits beside the comparator in the misc test hierarchy and is started and read by a bring-up controller or simulation harness.

## Interface
- NUM_RANDOM, 1000 — random vectors per run; range 1..65531.
- SEED_A, 32'hACE1_2468 — reset/start seed of the operand-A LFSR; must be nonzero.
- SEED_B, 32'h1357_9BDF — reset/start seed of the operand-B LFSR; must be nonzero.
- clk  in  1  — single clock; all state on the rising edge.
- rst_aL  in  1  — asynchronous, active-low reset.
- start  in  1  — begins a run; sampled only in IDLE or DONE.
- busy  out  1  — high while vectors are being applied.
- done  out  1  — level; high from run completion until the next start.
- pass  out  1  — equals done && (fail_cnt == 0).
- dut_a  out  32  — registered operand A to the comparator.
- dut_b  out  32  — registered operand B to the comparator.
- dut_y  in  1  — comparator result; combinational from dut_a/dut_b.
- pass_cnt  out  16  — vectors whose dut_y matched the golden result.
- fail_cnt  out  16  — vectors whose dut_y mismatched.

## Operation
- States: IDLE, RAND, DIR, DONE.
- IDLE/DONE + start=1 -> RAND. On that edge, reload both LFSRs from their seeds and clear the counters and the vector index.
- RAND: one vector per cycle, index k = 0..NUM_RANDOM-1.
  - dut_a = lfsr_a.
  - dut_b = lfsr_a when k[2:0]==3'b111; otherwise lfsr_b. This forces an equal pair every 8th vector.
  - Both LFSRs step once per vector. Galois form, polynomial x^32+x^22+x^2+x+1, mask 32'h8020_0003.
  - After the last random vector -> DIR.
- DIR: four vectors in order: (FFFFFFFF,FFFFFFFF), (00000000,FFFFFFFF), (FFFFFFFF,00000000), (00000000,00000000). After the fourth -> DONE.
- Check: in every RAND/DIR cycle, at the closing edge, compare dut_y with (dut_a == dut_b). Increment pass_cnt on a match and fail_cnt otherwise. Counters cannot overflow, because at most 65535 vectors are applied per run.
- DONE: dut_a, dut_b and the counters hold their last values. start re-arms a run.
- A start asserted in RAND or DIR is ignored.

## Timing
- Reset values: busy=0, done=0, pass=0, dut_a=0, dut_b=0, pass_cnt=0, fail_cnt=0, state=IDLE, LFSRs=seeds.
- Reset asserted mid-run aborts immediately; all outputs return to their reset values.
- The start edge is cycle 0. busy=1 and the first vector appear on dut_a/dut_b from cycle 1.
- The vector presented in cycle n is checked at the edge ending cycle n.
- Run length is NUM_RANDOM+4 busy cycles. done=1 and busy=0 in the cycle after the last check.
- Final counts and pass are valid in the same cycle done rises.

## Configuration
- CMP32_BIST_FAIL_CAPTURE_EN defined:
  - Adds outputs fail_a (32), fail_b (32), fail_y (1) and fail_idx (16), all reset to 0.
  - They latch dut_a, dut_b, dut_y and the global vector index (random 0..NUM_RANDOM-1, directed NUM_RANDOM..NUM_RANDOM+3) of the first mismatch in a run.
  - They are cleared on start.
- CMP32_BIST_FAIL_CAPTURE_EN undefined: the ports and capture registers are absent; all other behaviour is identical.

## Structure
- Package cmp32_bist_pkg holds:
  - the state enum;
  - the LFSR mask 32'h8020_0003;
  - the four directed operand pairs as constants;
  - the equal-pair period constant (8).
- Sub-module lfsr32: seed load, step enable and 32-bit state output. It is instantiated twice, once for A and once for B.

## Test plan
- Good comparator, NUM_RANDOM=16, pulse start -> busy for 20 cycles, then done=1, pass=1, pass_cnt=20, fail_cnt=0.
- dut_y stuck at 0, NUM_RANDOM=16 -> fail_cnt=4 (k=7, k=15, and directed vectors 0 and 3); pass_cnt=16; pass=0.
- dut_y stuck at 1, NUM_RANDOM=16 -> fail_cnt=16 (14 random plus directed vectors 1 and 2); pass_cnt=4.
- Run halfway, then assert rst_aL low for one cycle -> all outputs 0 and state IDLE. A new start completes a full run with identical counts.
- Assert start during RAND -> ignored; run length stays NUM_RANDOM+4. A start while done=1 re-runs with identical dut_a sequence (first dut_a=32'hACE1_2468).
- With CMP32_BIST_FAIL_CAPTURE_EN and an inverted dut_y -> fail_a=32'hACE1_2468, fail_b=32'h1357_9BDF, fail_y=1, fail_idx=0.

Source files
------------

// File: rtl/cmp32_bist_pkg.sv
// ---------------------------------------------------------------------------
// cmp32_bist_pkg
// Shared types and constants for the cmp32 BIST engine.
//   state_t      : BIST sequencer states (IDLE, RAND, DIR, DONE)
//   LFSR_MASK    : Galois feedback mask for x^32+x^22+x^2+x+1
//   DIR_A/DIR_B  : the four directed operand pairs, element 0 applied first
//   EQ_PERIOD    : every EQ_PERIOD-th random vector is forced to an equal pair
//   lfsr_step()  : one right-shift Galois step
// ---------------------------------------------------------------------------
package cmp32_bist_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RAND = 2'd1,
        ST_DIR  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    localparam logic [31:0] LFSR_MASK = 32'h8020_0003;

    // Packed as {pair3, pair2, pair1, pair0}.
    localparam logic [3:0][31:0] DIR_A = {32'h0000_0000, 32'hFFFF_FFFF,
                                          32'h0000_0000, 32'hFFFF_FFFF};
    localparam logic [3:0][31:0] DIR_B = {32'h0000_0000, 32'h0000_0000,
                                          32'hFFFF_FFFF, 32'hFFFF_FFFF};

    localparam int          EQ_PERIOD = 8;
    localparam logic [15:0] EQ_MASK   = 16'(EQ_PERIOD - 1);

    function automatic logic [31:0] lfsr_step(input logic [31:0] s);
        return {1'b0, s[31:1]} ^ (s[0] ? LFSR_MASK : 32'h0000_0000);
    endfunction

endpackage

// File: rtl/cmp32_bist_lfsr32.sv
// ---------------------------------------------------------------------------
// lfsr32
// 32-bit Galois LFSR (mask from cmp32_bist_pkg) with seed reload.
//   i_clk     : clock, rising edge
//   i_rst_aL  : asynchronous active-low reset, state returns to SEED
//   i_load    : reload SEED (has priority over i_step)
//   i_step    : advance one step
//   o_state   : current LFSR state
// ---------------------------------------------------------------------------
module lfsr32
    import cmp32_bist_pkg::*;
#(
    parameter logic [31:0] SEED = 32'h0000_0001
) (
    input  logic        i_clk,
    input  logic        i_rst_aL,
    input  logic        i_load,
    input  logic        i_step,
    output logic [31:0] o_state
);

    logic [31:0] r_state;

    always_ff @(posedge i_clk or negedge i_rst_aL) begin
        if (!i_rst_aL) begin
            r_state <= SEED;
        end else if (i_load) begin
            r_state <= SEED;
        end else if (i_step) begin
            r_state <= lfsr_step(r_state);
        end
    end

    assign o_state = r_state;

endmodule

// File: rtl/cmp32_bist.sv
// ---------------------------------------------------------------------------
// cmp32_bist
// Built-in self-test engine for the 32-bit equality comparator cmp32.
// Applies NUM_RANDOM LFSR vectors then four directed corner vectors, checks
// the comparator result every cycle against (dut_a == dut_b), counts results.
//
// Ports:
//   clk, rst_aL          : clock (rising edge), async active-low reset
//   start                : run request, sampled only in IDLE or DONE
//   busy, done, pass     : status (done is a level until the next start)
//   dut_a, dut_b         : registered operands to the comparator
//   dut_y                : comparator result, combinational from dut_a/dut_b
//   pass_cnt, fail_cnt   : per-run match / mismatch counts
//   fail_a/b/y/idx       : first-mismatch capture (only with
//                          CMP32_BIST_FAIL_CAPTURE_EN defined)
//   dbg_state            : current sequencer state (state_t encoding)
//
// Handshake: start is a level sampled on the rising edge; it is acted on only
// when the sequencer is IDLE or DONE and ignored while busy. There is no
// back-pressure on dut_y: it is checked at the edge closing each busy cycle.
// ---------------------------------------------------------------------------
module cmp32_bist
    import cmp32_bist_pkg::*;
#(
    parameter int          NUM_RANDOM = 1000,
    parameter logic [31:0] SEED_A     = 32'hACE1_2468,
    parameter logic [31:0] SEED_B     = 32'h1357_9BDF
) (
    input  logic        clk,
    input  logic        rst_aL,
    input  logic        start,
    output logic        busy,
    output logic        done,
    output logic        pass,
    output logic [31:0] dut_a,
    output logic [31:0] dut_b,
    input  logic        dut_y,
    output logic [15:0] pass_cnt,
    output logic [15:0] fail_cnt,
`ifdef CMP32_BIST_FAIL_CAPTURE_EN
    output logic [31:0] fail_a,
    output logic [31:0] fail_b,
    output logic        fail_y,
    output logic [15:0] fail_idx,
`endif
    output logic [1:0]  dbg_state
);

    localparam logic [15:0] LP_LAST_RAND = 16'(NUM_RANDOM - 1);

    state_t      r_state;
    state_t      w_state_next;
    logic [15:0] r_idx;       // global vector index of the vector on dut_a/b
    logic [1:0]  r_dir;       // which directed pair is currently presented
    logic [15:0] r_pass_cnt;
    logic [15:0] r_fail_cnt;
    logic [31:0] r_dut_a;
    logic [31:0] r_dut_b;

    logic        w_start_ok;
    logic        w_active;
    logic        w_last_rand;
    logic        w_last_dir;
    logic        w_match;
    logic [15:0] w_idx_next;
    logic        w_eq_next;
    logic [1:0]  w_dir_next;
    logic [31:0] w_lfsr_a;
    logic [31:0] w_lfsr_b;
    logic [31:0] w_lfsr_a_next;
    logic [31:0] w_lfsr_b_next;

    assign w_start_ok  = start && ((r_state == ST_IDLE) || (r_state == ST_DONE));
    assign w_active    = (r_state == ST_RAND) || (r_state == ST_DIR);
    assign w_last_rand = (r_state == ST_RAND) && (r_idx == LP_LAST_RAND);
    assign w_last_dir  = (r_state == ST_DIR) && (r_dir == 2'd3);
    assign w_match     = (dut_y == (r_dut_a == r_dut_b));
    assign w_idx_next  = r_idx + 16'd1;
    // Index of the vector about to be loaded decides the forced-equal pair.
    assign w_eq_next   = ((w_idx_next & EQ_MASK) == EQ_MASK);
    assign w_dir_next  = r_dir + 2'd1;

    // The LFSRs hold the value for the vector currently presented; the
    // registered operands are loaded from one step ahead.
    lfsr32 #(.SEED(SEED_A)) u_lfsr_a (
        .i_clk    (clk),
        .i_rst_aL (rst_aL),
        .i_load   (w_start_ok),
        .i_step   (r_state == ST_RAND),
        .o_state  (w_lfsr_a)
    );

    lfsr32 #(.SEED(SEED_B)) u_lfsr_b (
        .i_clk    (clk),
        .i_rst_aL (rst_aL),
        .i_load   (w_start_ok),
        .i_step   (r_state == ST_RAND),
        .o_state  (w_lfsr_b)
    );

    assign w_lfsr_a_next = lfsr_step(w_lfsr_a);
    assign w_lfsr_b_next = lfsr_step(w_lfsr_b);

    // -------------------------------------------------------------------
    // Sequencer
    // -------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_aL) begin
        if (!rst_aL) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE, ST_DONE: if (start)       w_state_next = ST_RAND;
            ST_RAND:          if (w_last_rand) w_state_next = ST_DIR;
            ST_DIR:           if (w_last_dir)  w_state_next = ST_DONE;
            default:                           w_state_next = ST_IDLE;
        endcase
    end

    // -------------------------------------------------------------------
    // Operand generation and result counting
    // -------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_aL) begin
        if (!rst_aL) begin
            r_idx      <= 16'd0;
            r_dir      <= 2'd0;
            r_pass_cnt <= 16'd0;
            r_fail_cnt <= 16'd0;
            r_dut_a    <= 32'd0;
            r_dut_b    <= 32'd0;
        end else if (w_start_ok) begin
            // Vector 0 is the seed pair itself (index 0 is never forced equal).
            r_idx      <= 16'd0;
            r_dir      <= 2'd0;
            r_pass_cnt <= 16'd0;
            r_fail_cnt <= 16'd0;
            r_dut_a    <= SEED_A;
            r_dut_b    <= SEED_B;
        end else if (w_active) begin
            if (w_match) r_pass_cnt <= r_pass_cnt + 16'd1;
            else         r_fail_cnt <= r_fail_cnt + 16'd1;

            if (r_state == ST_RAND) begin
                r_idx <= w_idx_next;
                if (w_last_rand) begin
                    r_dir   <= 2'd0;
                    r_dut_a <= DIR_A[0];
                    r_dut_b <= DIR_B[0];
                end else begin
                    r_dut_a <= w_lfsr_a_next;
                    r_dut_b <= w_eq_next ? w_lfsr_a_next : w_lfsr_b_next;
                end
            end else if (!w_last_dir) begin
                // After the last directed pair, operands hold for DONE.
                r_idx   <= w_idx_next;
                r_dir   <= w_dir_next;
                r_dut_a <= DIR_A[w_dir_next];
                r_dut_b <= DIR_B[w_dir_next];
            end
        end
    end

`ifdef CMP32_BIST_FAIL_CAPTURE_EN
    logic [31:0] r_fail_a;
    logic [31:0] r_fail_b;
    logic        r_fail_y;
    logic [15:0] r_fail_idx;

    // A zero fail count means no mismatch has been captured yet this run.
    always_ff @(posedge clk or negedge rst_aL) begin
        if (!rst_aL) begin
            r_fail_a   <= 32'd0;
            r_fail_b   <= 32'd0;
            r_fail_y   <= 1'b0;
            r_fail_idx <= 16'd0;
        end else if (w_start_ok) begin
            r_fail_a   <= 32'd0;
            r_fail_b   <= 32'd0;
            r_fail_y   <= 1'b0;
            r_fail_idx <= 16'd0;
        end else if (w_active && !w_match && (r_fail_cnt == 16'd0)) begin
            r_fail_a   <= r_dut_a;
            r_fail_b   <= r_dut_b;
            r_fail_y   <= dut_y;
            r_fail_idx <= r_idx;
        end
    end

    assign fail_a   = r_fail_a;
    assign fail_b   = r_fail_b;
    assign fail_y   = r_fail_y;
    assign fail_idx = r_fail_idx;
`endif

    assign busy      = w_active;
    assign done      = (r_state == ST_DONE);
    assign pass      = done && (r_fail_cnt == 16'd0);
    assign dut_a     = r_dut_a;
    assign dut_b     = r_dut_b;
    assign pass_cnt  = r_pass_cnt;
    assign fail_cnt  = r_fail_cnt;
    assign dbg_state = r_state;

endmodule

// File: tb/tb_cmp32_bist.sv
// ---------------------------------------------------------------------------
// tb_cmp32_bist
// Directed bench for cmp32_bist (NUM_RANDOM = 16). The bench plays the
// comparator itself: y_mode selects a good comparator, stuck-at-0,
// stuck-at-1 or an inverted output. Define CMP32_BIST_FAIL_CAPTURE_EN to
// also check the first-mismatch capture ports.
// ---------------------------------------------------------------------------
module tb_cmp32_bist;

    localparam int NR = 16;

    logic        clk;
    logic        rst_aL;
    logic        start;
    logic        busy;
    logic        done;
    logic        pass;
    logic [31:0] dut_a;
    logic [31:0] dut_b;
    logic        dut_y;
    logic [15:0] pass_cnt;
    logic [15:0] fail_cnt;
    logic [1:0]  dbg_state;
`ifdef CMP32_BIST_FAIL_CAPTURE_EN
    logic [31:0] fail_a;
    logic [31:0] fail_b;
    logic        fail_y;
    logic [15:0] fail_idx;
`endif

    int y_mode;     // 0 good, 1 stuck-0, 2 stuck-1, 3 inverted
    int n_assert;
    int n_fail;
    int busy_cnt;

    // ---------------- clock / reset block ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Comparator model driven back into the BIST engine.
    assign dut_y = (y_mode == 1) ? 1'b0 :
                   (y_mode == 2) ? 1'b1 :
                   (y_mode == 3) ? (dut_a != dut_b) :
                                   (dut_a == dut_b);

    always @(negedge clk) if (busy === 1'b1) busy_cnt++;

    cmp32_bist #(
        .NUM_RANDOM (NR),
        .SEED_A     (32'hACE1_2468),
        .SEED_B     (32'h1357_9BDF)
    ) u_dut (
        .clk       (clk),
        .rst_aL    (rst_aL),
        .start     (start),
        .busy      (busy),
        .done      (done),
        .pass      (pass),
        .dut_a     (dut_a),
        .dut_b     (dut_b),
        .dut_y     (dut_y),
        .pass_cnt  (pass_cnt),
        .fail_cnt  (fail_cnt),
`ifdef CMP32_BIST_FAIL_CAPTURE_EN
        .fail_a    (fail_a),
        .fail_b    (fail_b),
        .fail_y    (fail_y),
        .fail_idx  (fail_idx),
`endif
        .dbg_state (dbg_state)
    );

    // ---------------- driver tasks ----------------
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Leaves the bench at the falling edge of cycle 1 (first vector shown).
    task automatic pulse_start();
        busy_cnt = 0;
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
    endtask

    // Bounded wait for done; stops on the first falling edge with done=1.
    task automatic wait_done();
        int t;
        t = 0;
        while (done !== 1'b1 && t < 500) begin
            @(negedge clk);
            t++;
        end
    endtask

    task automatic check_final(input string tag, input logic [15:0] exp_pass,
                               input logic [15:0] exp_fail, input logic exp_ok);
        check({tag, "_done"},     done,     1'b1);
        check({tag, "_busy"},     busy,     1'b0);
        check({tag, "_busy_len"}, busy_cnt, NR + 4);
        check({tag, "_pass_cnt"}, pass_cnt, exp_pass);
        check({tag, "_fail_cnt"}, fail_cnt, exp_fail);
        check({tag, "_pass"},     pass,     exp_ok);
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        n_assert = 0;
        n_fail   = 0;
        busy_cnt = 0;
        y_mode   = 0;
        rst_aL   = 1'b0;
        start    = 1'b0;
        repeat (2) @(negedge clk);

        check("rst_busy",     busy,      1'b0);
        check("rst_done",     done,      1'b0);
        check("rst_pass",     pass,      1'b0);
        check("rst_dut_a",    dut_a,     32'h0);
        check("rst_dut_b",    dut_b,     32'h0);
        check("rst_pass_cnt", pass_cnt,  16'h0);
        check("rst_fail_cnt", fail_cnt,  16'h0);
        check("rst_state",    dbg_state, 2'd0);
        rst_aL = 1'b1;
        @(negedge clk);
        check("idle_state",   dbg_state, 2'd0);

        // Good comparator: first two vectors are hand-stepped from the seeds.
        pulse_start();
        check("run1_busy",    busy,  1'b1);
        check("run1_a0",      dut_a, 32'hACE1_2468);
        check("run1_b0",      dut_b, 32'h1357_9BDF);
        @(negedge clk);
        check("run1_a1",      dut_a, 32'h5670_9234);
        check("run1_b1",      dut_b, 32'h898B_CDEC);
        wait_done();
        check_final("run1", 16'd20, 16'd0, 1'b1);
        check("run1_hold_a",  dut_a, 32'h0);
        check("run1_hold_b",  dut_b, 32'h0);
        check("run1_state",   dbg_state, 2'd3);

        // Start during RAND must be ignored.
        pulse_start();
        repeat (5) @(negedge clk);
        start = 1'b1;
        @(negedge clk) start = 1'b0;
        check("ign_still_busy", busy, 1'b1);
        wait_done();
        check_final("ign", 16'd20, 16'd0, 1'b1);

        // Re-run from DONE replays the same first vector.
        pulse_start();
        check("rerun_done_low", done,  1'b0);
        check("rerun_a0",       dut_a, 32'hACE1_2468);
        wait_done();
        check_final("rerun", 16'd20, 16'd0, 1'b1);

        // Reset in the middle of a run aborts it.
        pulse_start();
        repeat (8) @(negedge clk);
        rst_aL = 1'b0;
        #1;
        check("mid_rst_busy",     busy,      1'b0);
        check("mid_rst_done",     done,      1'b0);
        check("mid_rst_pass",     pass,      1'b0);
        check("mid_rst_dut_a",    dut_a,     32'h0);
        check("mid_rst_dut_b",    dut_b,     32'h0);
        check("mid_rst_pass_cnt", pass_cnt,  16'h0);
        check("mid_rst_fail_cnt", fail_cnt,  16'h0);
        check("mid_rst_state",    dbg_state, 2'd0);
        @(negedge clk) rst_aL = 1'b1;
        @(negedge clk);
        check("post_rst_state",   dbg_state, 2'd0);
        pulse_start();
        check("post_rst_a0",      dut_a, 32'hACE1_2468);
        wait_done();
        check_final("post_rst", 16'd20, 16'd0, 1'b1);

        // Stuck-at-0: misses k=7, k=15, directed 0 and 3.
        y_mode = 1;
        pulse_start();
        wait_done();
        check_final("stuck0", 16'd16, 16'd4, 1'b0);
`ifdef CMP32_BIST_FAIL_CAPTURE_EN
        check("stuck0_fail_idx", fail_idx, 16'd7);
        check("stuck0_fail_y",   fail_y,   1'b0);
`endif

        // Stuck-at-1: 14 unequal random plus directed 1 and 2.
        y_mode = 2;
        pulse_start();
        wait_done();
        check_final("stuck1", 16'd4, 16'd16, 1'b0);

        // Inverted comparator: every vector fails; first is the seed pair.
        y_mode = 3;
        pulse_start();
        wait_done();
        check_final("inv", 16'd0, 16'd20, 1'b0);
`ifdef CMP32_BIST_FAIL_CAPTURE_EN
        check("inv_fail_a",   fail_a,   32'hACE1_2468);
        check("inv_fail_b",   fail_b,   32'h1357_9BDF);
        check("inv_fail_y",   fail_y,   1'b1);
        check("inv_fail_idx", fail_idx, 16'd0);
`endif

        // ---------------- final report ----------------
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
